avalon_burst_ram_slave: RTL and testbench
=========================================

AVALON_BURST_RAM_SLAVE -- requirements
Module: avalon_burst_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 13, meaning memory depth is 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 30'h0, meaning word base address of the region; only bits [29:ADDR_BITS] are compared.
REQ-003 SHALL have port clk  in  1  meaning sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port bus_address  in  30  meaning word address.
REQ-006 SHALL have port bus_burstcount  in  5  meaning beats requested.
REQ-007 SHALL have ports bus_read and bus_write  in  1 each  meaning command/write-beat strobes.
REQ-008 SHALL have port bus_writedata  in  32  meaning write beat data.
REQ-009 SHALL have port bus_byteenable  in  4  meaning per-beat byte lanes.
REQ-010 SHALL have port s_waitrequest  out  1  meaning command stall.
REQ-011 SHALL have port s_readdata  out  32  meaning read beat data.
REQ-012 SHALL have port s_readdatavalid  out  1  meaning read beat strobe.
REQ-013 SHALL have port s_writeresponsevalid  out  1  meaning write completion strobe.
REQ-014 SHALL have port s_response  out  2  meaning 00 OKAY, 10 SLVERR; valid only with a strobe.

Function
REQ-015 SHALL assert sel = (bus_address[29:ADDR_BITS] == BASE_ADDR[29:ADDR_BITS]) & (bus_read | bus_write), evaluated only in IDLE.
REQ-016 SHALL drive all five outputs to 0 whenever not selected and not strobing, because slave outputs are OR-combined on the shared bus.
REQ-017 SHALL implement states IDLE, READ, WRITE, WRESP.
REQ-018 SHALL in IDLE hold s_waitrequest=0 and accept a selected command in the same cycle (cycle T).
REQ-019 SHALL treat burstcount 0 as 1; burstcount 1..16 legal; 17..31 are an error burst (REQ-026).
REQ-020 SHALL on read accept capture address and N, issue synchronous RAM reads at addr, addr+1, ..., and go READ.
REQ-021 SHALL return read beat k (0..N-1) at cycle T+1+k with s_readdatavalid=1, s_response=00, consecutive beats without gaps.
REQ-022 SHALL return to IDLE in the cycle after the final beat; beat address increment SHALL wrap modulo 2^ADDR_BITS.
REQ-023 SHALL on write accept write beat 0 to addr under bus_byteenable; if N=1 go WRESP, else go WRITE with remaining=N-1.
REQ-024 SHALL in WRITE write one beat per cycle with bus_write=1 (address/select ignored, next sequential address, per-beat byteenable), hold s_waitrequest=0, stall on bus_write=0, and go WRESP after the last beat.
REQ-025 SHALL in WRESP pulse s_writeresponsevalid=1, s_response=00 for exactly one cycle, then go IDLE.
REQ-026 SHALL for an error burst: read -> one beat, s_readdata=0, s_response=10; write -> no memory update, single WRESP pulse with s_response=10.
REQ-027 SHALL in READ, WRITE (non-write-beat), WRESP assert s_waitrequest=1 only if a region-matching bus_read or bus_write is present; otherwise 0.
REQ-028 SHALL drive s_readdata=0 in every cycle s_readdatavalid=0.
REQ-029 SHALL give bus_read priority over bus_write if both asserted in IDLE.

Reset
REQ-030 SHALL on rst_n=0 asynchronously enter IDLE, clear counters, and drive all outputs to 0.
REQ-031 SHALL abandon any in-flight burst on reset with no further strobes; memory contents are not cleared (undefined at power-up).
REQ-032 SHALL accept a command in the first cycle after rst_n deasserts.

Verification
REQ-033 Write 0xDEADBEEF at BASE+4, be=4'hF, N=1 -> s_writeresponsevalid at T+1, resp 00; read N=1 -> 0xDEADBEEF at T+1.
REQ-034 16-beat write of 0..15 at BASE, then 16-beat read -> readdatavalid T+1..T+16 contiguous, data 0..15, resp 00.
REQ-035 Write be=4'b0010 data 0xFFFFFFFF over 0x00000000 -> readback 0x0000FF00.
REQ-036 4-beat read at BASE+(2^ADDR_BITS-2) -> data from words D-2, D-1, 0, 1.
REQ-037 Read with burstcount 20 -> one beat, data 0, resp 10; out-of-region read -> all outputs remain 0.
REQ-038 Assert rst_n=0 mid 16-beat read at beat 5 -> outputs 0 immediately; after release, new N=1 read returns correct data at T+1.

Source files
------------

// File: rtl/avalon_burst_ram_slave.sv
// ============================================================================
// Module   : avalon_burst_ram_slave
// Brief    : Avalon-MM burst slave over a single-port synchronous word RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avalon_burst_ram_slave #(
    parameter int          ADDR_BITS = 13,
    parameter logic [29:0] BASE_ADDR = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] bus_address,
    input  logic [4:0]  bus_burstcount,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_writedata,
    input  logic [3:0]  bus_byteenable,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    output logic        s_writeresponsevalid,
    output logic [1:0]  s_response
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [4:0]           left_q, left_d;
    logic                 err_q, err_d;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          ram_q;

    logic                 region;
    logic                 cmd_sel;
    logic [4:0]           beats;
    logic                 beats_err;
    logic                 re;
    logic                 we;
    logic [ADDR_BITS-1:0] raddr;
    logic [ADDR_BITS-1:0] waddr;

    // Only address bits above the RAM index take part in region decode.
    assign region    = ((bus_address ^ BASE_ADDR) >> ADDR_BITS) == 30'd0;
    assign cmd_sel   = region & (bus_read | bus_write);
    assign beats     = (bus_burstcount == 5'd0) ? 5'd1 : bus_burstcount;
    assign beats_err = beats > 5'd16;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        err_d   = err_q;
        re      = 1'b0;
        we      = 1'b0;
        raddr   = addr_q;
        waddr   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_sel) begin
                    err_d = beats_err;
                    if (bus_read) begin
                        re      = ~beats_err;
                        raddr   = bus_address[ADDR_BITS-1:0];
                        addr_d  = raddr + 1'b1;
                        left_d  = beats_err ? 5'd0 : beats - 5'd1;
                        state_d = S_READ;
                    end else begin
                        we      = ~beats_err;
                        waddr   = bus_address[ADDR_BITS-1:0];
                        addr_d  = waddr + 1'b1;
                        left_d  = beats - 5'd1;
                        state_d = (beats_err || beats == 5'd1) ? S_WRESP : S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (left_q != 5'd0) begin
                    re     = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - 5'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (bus_write) begin
                    we     = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - 5'd1;
                    if (left_q == 5'd1) begin
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            left_q  <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; strobes are gated so nothing lands while in reset.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_byteenable[i]) begin
                    mem[waddr][8*i +: 8] <= bus_writedata[8*i +: 8];
                end
            end
        end
        if (re && rst_n) begin
            ram_q <= mem[raddr];
        end
    end

    assign s_readdatavalid      = (state_q == S_READ);
    assign s_writeresponsevalid = (state_q == S_WRESP);
    assign s_readdata           = (s_readdatavalid && !err_q) ? ram_q : 32'd0;
    assign s_response           = ((s_readdatavalid || s_writeresponsevalid) && err_q) ? 2'b10 : 2'b00;
    assign s_waitrequest        = (state_q != S_IDLE) && cmd_sel &&
                                  !((state_q == S_WRITE) && bus_write);

endmodule

`default_nettype wire

// File: tb/tb_avalon_burst_ram_slave.sv
// ============================================================================
// Module   : tb_avalon_burst_ram_slave
// Brief    : Self-checking bench for avalon_burst_ram_slave against an array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avalon_burst_ram_slave;

    localparam int          AB   = 6;
    localparam int          D    = 1 << AB;
    localparam logic [29:0] BASE = 30'h1C0;

    logic        clk;
    logic        rst_n;
    logic [29:0] bus_address;
    logic [4:0]  bus_burstcount;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        s_writeresponsevalid;
    logic [1:0]  s_response;

    logic [31:0] ref_mem [D];
    logic [31:0] wd [16];
    logic [3:0]  wb [16];
    int          total;
    int          bad;

    avalon_burst_ram_slave #(
        .ADDR_BITS (AB),
        .BASE_ADDR (BASE)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus_address          (bus_address),
        .bus_burstcount       (bus_burstcount),
        .bus_read             (bus_read),
        .bus_write            (bus_write),
        .bus_writedata        (bus_writedata),
        .bus_byteenable       (bus_byteenable),
        .s_waitrequest        (s_waitrequest),
        .s_readdata           (s_readdata),
        .s_readdatavalid      (s_readdatavalid),
        .s_writeresponsevalid (s_writeresponsevalid),
        .s_response           (s_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] all_outs();
        return {s_waitrequest, s_readdatavalid, s_writeresponsevalid, s_response, s_readdata};
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) ref_mem[idx % D][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic do_write(input logic [29:0] a, input logic [4:0] bc, input bit stall);
        int n;
        bit err;
        n   = (bc == 5'd0) ? 1 : int'(bc);
        err = n > 16;
        bus_read = 1'b0; bus_write = 1'b1; bus_address = a; bus_burstcount = bc;
        bus_writedata = wd[0]; bus_byteenable = wb[0];
        #1;
        total++;
        if (s_waitrequest !== 1'b0) begin
            bad++; $display("FAIL wr_accept_wait a=%h got=%b want=0", a, s_waitrequest);
        end
        @(posedge clk); #1;
        if (!err) begin
            model_write(int'(a[AB-1:0]), wd[0], wb[0]);
            for (int k = 1; k < n; k++) begin
                if (stall && $urandom_range(0, 2) == 0) begin
                    bus_write = 1'b0; bus_address = 30'($urandom);
                    #1;
                    total++;
                    if (s_writeresponsevalid !== 1'b0) begin
                        bad++; $display("FAIL wr_stall_resp beat=%0d got=%b want=0", k, s_writeresponsevalid);
                    end
                    @(posedge clk); #1;
                end
                bus_write = 1'b1; bus_address = 30'($urandom);
                bus_writedata = wd[k]; bus_byteenable = wb[k];
                @(posedge clk); #1;
                model_write(int'(a[AB-1:0]) + k, wd[k], wb[k]);
            end
        end
        bus_write = 1'b0;
        #1;
        total++;
        if ({s_writeresponsevalid, s_response, s_readdatavalid} !== {1'b1, (err ? 2'b10 : 2'b00), 1'b0}) begin
            bad++; $display("FAIL wr_resp a=%h n=%0d got=%b%b%b want=1%b0", a, n,
                            s_writeresponsevalid, s_response, s_readdatavalid, (err ? 2'b10 : 2'b00));
        end
        @(posedge clk); #1;
        total++;
        if (s_writeresponsevalid !== 1'b0) begin
            bad++; $display("FAIL wr_resp_once a=%h got=%b want=0", a, s_writeresponsevalid);
        end
    endtask

    task automatic do_read(input logic [29:0] a, input logic [4:0] bc);
        int n;
        bit err;
        logic [34:0] exp;
        n   = (bc == 5'd0) ? 1 : int'(bc);
        err = n > 16;
        bus_read = 1'b1; bus_write = 1'b0; bus_address = a; bus_burstcount = bc;
        #1;
        total++;
        if (s_waitrequest !== 1'b0) begin
            bad++; $display("FAIL rd_accept_wait a=%h got=%b want=0", a, s_waitrequest);
        end
        @(posedge clk); #1;
        bus_read = 1'b0;
        for (int k = 0; k < (err ? 1 : n); k++) begin
            exp = err ? {1'b1, 2'b10, 32'd0} : {1'b1, 2'b00, ref_mem[(int'(a[AB-1:0]) + k) % D]};
            total++;
            if ({s_readdatavalid, s_response, s_readdata} !== exp) begin
                bad++; $display("FAIL rd_beat a=%h k=%0d got=%b/%b/%h want=%b/%b/%h", a, k,
                                s_readdatavalid, s_response, s_readdata, exp[34], exp[33:32], exp[31:0]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (all_outs() !== 37'd0) begin
            bad++; $display("FAIL rd_end_idle a=%h got=%h want=0", a, all_outs());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_read = 1'b0; bus_write = 1'b0; bus_address = '0;
        bus_burstcount = '0; bus_writedata = '0; bus_byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (all_outs() !== 37'd0) begin
            bad++; $display("FAIL reset_outs got=%h want=0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int b = 0; b < D / 16; b++) begin
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; wb[k] = 4'hF; end
            do_write(BASE + 30'(16 * b), 5'd16, 1'b0);
        end
        do_read(BASE, 5'd16);
    endtask

    task automatic test_single();
        wd[0] = 32'hDEADBEEF; wb[0] = 4'hF;
        do_write(BASE + 30'd4, 5'd1, 1'b0);
        do_read(BASE + 30'd4, 5'd1);
        total++;
        if (ref_mem[4] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_model got=%h want=deadbeef", ref_mem[4]);
        end
        do_read(BASE + 30'd4, 5'd0);
    endtask

    task automatic test_burst16();
        for (int k = 0; k < 16; k++) begin wd[k] = 32'(k); wb[k] = 4'hF; end
        do_write(BASE, 5'd16, 1'b0);
        do_read(BASE, 5'd16);
    endtask

    task automatic test_byteenable();
        wd[0] = 32'h0; wb[0] = 4'hF;
        do_write(BASE + 30'd9, 5'd1, 1'b0);
        wd[0] = 32'hFFFFFFFF; wb[0] = 4'b0010;
        do_write(BASE + 30'd9, 5'd1, 1'b0);
        total++;
        if (ref_mem[9] !== 32'h0000FF00) begin
            bad++; $display("FAIL be_model got=%h want=0000ff00", ref_mem[9]);
        end
        do_read(BASE + 30'd9, 5'd1);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hA500_0000 + 32'(k); wb[k] = 4'hF; end
        do_write(BASE + 30'(D - 2), 5'd4, 1'b1);
        do_read(BASE + 30'(D - 2), 5'd4);
    endtask

    task automatic test_error();
        logic [31:0] keep;
        do_read(BASE + 30'd3, 5'd20);
        keep = ref_mem[12];
        wd[0] = ~keep; wb[0] = 4'hF;
        do_write(BASE + 30'd12, 5'd31, 1'b0);
        do_read(BASE + 30'd12, 5'd1);
        total++;
        if (ref_mem[12] !== keep) begin
            bad++; $display("FAIL err_wr_model got=%h want=%h", ref_mem[12], keep);
        end
    endtask

    task automatic test_out_of_region();
        bus_address = BASE ^ 30'h200; bus_burstcount = 5'd1;
        bus_writedata = $urandom; bus_byteenable = 4'hF;
        for (int c = 0; c < 4; c++) begin
            bus_read = (c < 2); bus_write = (c >= 2);
            #1;
            total++;
            if (all_outs() !== 37'd0) begin
                bad++; $display("FAIL oor_outs c=%0d got=%h want=0", c, all_outs());
            end
            @(posedge clk); #1;
        end
        bus_read = 1'b0; bus_write = 1'b0;
        do_read(BASE + 30'd0, 5'd2);
    endtask

    task automatic test_waitrequest();
        bus_read = 1'b1; bus_address = BASE + 30'd8; bus_burstcount = 5'd4;
        @(posedge clk); #1;
        bus_address = BASE + 30'd20; bus_burstcount = 5'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if ({s_waitrequest, s_readdatavalid, s_readdata} !== {1'b1, 1'b1, ref_mem[8 + k]}) begin
                bad++; $display("FAIL wait_busy k=%0d got=%b/%b/%h want=1/1/%h", k,
                                s_waitrequest, s_readdatavalid, s_readdata, ref_mem[8 + k]);
            end
            @(posedge clk); #1;
        end
        total++;
        if ({s_waitrequest, s_readdatavalid} !== 2'b00) begin
            bad++; $display("FAIL wait_release got=%b%b want=00", s_waitrequest, s_readdatavalid);
        end
        @(posedge clk); #1;
        bus_read = 1'b0;
        total++;
        if ({s_readdatavalid, s_readdata} !== {1'b1, ref_mem[20]}) begin
            bad++; $display("FAIL wait_queued got=%b/%h want=1/%h", s_readdatavalid, s_readdata, ref_mem[20]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [29:0] a;
        logic [4:0]  bc;
        for (int t = 0; t < 40; t++) begin
            a  = BASE | 30'($urandom_range(0, D - 1));
            bc = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 16; k++) begin wd[k] = $urandom; wb[k] = 4'($urandom); end
                do_write(a, bc, 1'b1);
            end else begin
                do_read(a, bc);
            end
        end
    endtask

    task automatic test_reset_midburst();
        bus_read = 1'b1; bus_address = BASE; bus_burstcount = 5'd16;
        @(posedge clk); #1;
        bus_read = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        total++;
        if ({s_readdatavalid, s_readdata} !== {1'b1, ref_mem[5]}) begin
            bad++; $display("FAIL mid_beat5 got=%b/%h want=1/%h", s_readdatavalid, s_readdata, ref_mem[5]);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (all_outs() !== 37'd0) begin
            bad++; $display("FAIL mid_reset_async got=%h want=0", all_outs());
        end
        @(posedge clk); #1;
        total++;
        if (all_outs() !== 37'd0) begin
            bad++; $display("FAIL mid_reset_hold got=%h want=0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_read(BASE + 30'd7, 5'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_single();
        test_burst16();
        test_byteenable();
        test_wrap();
        test_error();
        test_out_of_region();
        test_waitrequest();
        test_back_to_back();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
